rv32_decode_exec: RTL and testbench

Combinational RV32I execute stage for a single-cycle core. It decodes the current instruction and computes every ALU result it needs. It also produces the register-file and data-memory control fields and selects the next PC. It sits between the instruction register / register file and the PC register. The data-memory read path and register-write mux sit outside the block.

---
 rtl/rv32_decode_exec.sv | 268 ++++++++++++++++++++++++++
 tb/tb_rv32_decode_exec.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rv32_decode_exec.sv
//------------------------------------------------------------------------------
// Module      : rv32_decode_exec
// Description : Combinational RV32I decode/execute stage: ALU, register-file
//               and data-memory controls, next-PC selection, illegal detect.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rv32_decode_exec (
  input  logic        iwnRst,
  input  logic [31:0] iwInstruction,
  input  logic [31:0] iwPc,
  input  logic [31:0] iwReg1Value,
  input  logic [31:0] iwReg2Value,
  output logic [4:0]  owReadReg1,
  output logic [4:0]  owReadReg2,
  output logic [4:0]  owWriteReg,
  output logic [1:0]  owWriteRegSource,
  output logic [31:0] owWriteRegImmediate,
  output logic [31:0] owAluResult,
  output logic        owDMemWrite,
  output logic [1:0]  owDMemAccess,
  output logic        owDMemSignExtend,
  output logic [31:0] owNextPc,
  output logic        onIllegal
);

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_OP     = 7'b0110011;
  localparam logic [6:0] C_OP_LUI    = 7'b0110111;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;

  localparam logic [3:0] C_ALU_ADD  = 4'd0;
  localparam logic [3:0] C_ALU_SUB  = 4'd1;
  localparam logic [3:0] C_ALU_SLL  = 4'd2;
  localparam logic [3:0] C_ALU_SLT  = 4'd3;
  localparam logic [3:0] C_ALU_SLTU = 4'd4;
  localparam logic [3:0] C_ALU_XOR  = 4'd5;
  localparam logic [3:0] C_ALU_SRL  = 4'd6;
  localparam logic [3:0] C_ALU_SRA  = 4'd7;
  localparam logic [3:0] C_ALU_OR   = 4'd8;
  localparam logic [3:0] C_ALU_AND  = 4'd9;

  localparam logic [1:0] C_SRC_ALU = 2'b00;
  localparam logic [1:0] C_SRC_MEM = 2'b01;
  localparam logic [1:0] C_SRC_IMM = 2'b10;

  // Reset substitutes a NOP so the rest of the decode needs no reset awareness
  logic [31:0] w_instr;
  assign w_instr = iwnRst ? iwInstruction : C_NOP;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  assign w_opcode = w_instr[6:0];
  assign w_funct3 = w_instr[14:12];
  assign w_funct7 = w_instr[31:25];
  assign w_rd     = w_instr[11:7];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];

  logic [31:0] w_immI;
  logic [31:0] w_immS;
  logic [31:0] w_immB;
  logic [31:0] w_immU;
  logic [31:0] w_immJ;
  assign w_immI = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_immS = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_immB = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_immU = {w_instr[31:12], 12'b0};
  assign w_immJ = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

  logic [31:0] w_pcPlus4;
  assign w_pcPlus4 = iwPc + 32'd4;

  logic        w_legal;
  logic [4:0]  w_readReg1;
  logic [4:0]  w_readReg2;
  logic [4:0]  w_writeReg;
  logic [1:0]  w_writeSrc;
  logic [31:0] w_writeImm;
  logic [3:0]  w_aluOp;
  logic        w_useReg2;
  logic        w_useImmS;
  logic        w_dmemWrite;
  logic [1:0]  w_dmemAccess;
  logic        w_signExt;
  logic        w_isBranch;
  logic        w_inverted;
  logic        w_isJal;
  logic        w_isJalr;

  // funct3 to ALU op for OP / OP-IMM; alt selects SUB/SRA
  function automatic logic [3:0] f_arithOp(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  f_arithOp = alt ? C_ALU_SUB : C_ALU_ADD;
      3'b001:  f_arithOp = C_ALU_SLL;
      3'b010:  f_arithOp = C_ALU_SLT;
      3'b011:  f_arithOp = C_ALU_SLTU;
      3'b100:  f_arithOp = C_ALU_XOR;
      3'b101:  f_arithOp = alt ? C_ALU_SRA : C_ALU_SRL;
      3'b110:  f_arithOp = C_ALU_OR;
      default: f_arithOp = C_ALU_AND;
    endcase
  endfunction

  always_comb begin
    w_legal      = 1'b0;
    w_readReg1   = 5'd0;
    w_readReg2   = 5'd0;
    w_writeReg   = 5'd0;
    w_writeSrc   = C_SRC_ALU;
    w_writeImm   = 32'd0;
    w_aluOp      = C_ALU_ADD;
    w_useReg2    = 1'b0;
    w_useImmS    = 1'b0;
    w_dmemWrite  = 1'b0;
    w_dmemAccess = 2'b00;
    w_signExt    = 1'b0;
    w_isBranch   = 1'b0;
    w_inverted   = 1'b0;
    w_isJal      = 1'b0;
    w_isJalr     = 1'b0;

    if (w_instr[1:0] == 2'b11) begin
      case (w_opcode)
        C_OP_OP: begin
          w_legal    = (w_funct7 == 7'h00) ||
                       ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
          w_readReg1 = w_rs1;
          w_readReg2 = w_rs2;
          w_writeReg = w_rd;
          w_useReg2  = 1'b1;
          w_aluOp    = f_arithOp(w_funct3, w_funct7[5]);
        end
        C_OP_OPIMM: begin
          case (w_funct3)
            3'b001:  w_legal = (w_funct7 == 7'h00);
            3'b101:  w_legal = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
            default: w_legal = 1'b1;
          endcase
          w_readReg1 = w_rs1;
          w_writeReg = w_rd;
          // Only the shift-right encoding carries an alternate-op bit; ADDI never subtracts
          w_aluOp    = f_arithOp(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
        end
        C_OP_LUI: begin
          w_legal    = 1'b1;
          w_writeReg = w_rd;
          w_writeSrc = C_SRC_IMM;
          w_writeImm = w_immU;
        end
        C_OP_AUIPC: begin
          w_legal    = 1'b1;
          w_writeReg = w_rd;
          w_writeSrc = C_SRC_IMM;
          w_writeImm = iwPc + w_immU;
        end
        C_OP_LOAD: begin
          w_legal      = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) && (w_funct3 != 3'b111);
          w_readReg1   = w_rs1;
          w_writeReg   = w_rd;
          w_writeSrc   = C_SRC_MEM;
          w_dmemAccess = w_funct3[1:0];
          w_signExt    = ~w_funct3[2] & ~w_funct3[1];
        end
        C_OP_STORE: begin
          w_legal      = (w_funct3 < 3'b011);
          w_readReg1   = w_rs1;
          w_readReg2   = w_rs2;
          w_useImmS    = 1'b1;
          w_dmemWrite  = 1'b1;
          w_dmemAccess = w_funct3[1:0];
        end
        C_OP_BRANCH: begin
          w_legal    = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
          w_readReg1 = w_rs1;
          w_readReg2 = w_rs2;
          w_useReg2  = 1'b1;
          w_isBranch = 1'b1;
          // BEQ/BGE/BGEU take on the complement of the raw ALU flag
          w_inverted = w_funct3[2] ? w_funct3[0] : ~w_funct3[0];
          case (w_funct3[2:1])
            2'b10:   w_aluOp = C_ALU_SLT;
            2'b11:   w_aluOp = C_ALU_SLTU;
            default: w_aluOp = C_ALU_SUB;
          endcase
        end
        C_OP_JAL: begin
          w_legal    = 1'b1;
          w_writeReg = w_rd;
          w_writeSrc = C_SRC_IMM;
          w_writeImm = w_pcPlus4;
          w_isJal    = 1'b1;
        end
        C_OP_JALR: begin
          w_legal    = (w_funct3 == 3'b000);
          w_readReg1 = w_rs1;
          w_writeReg = w_rd;
          w_writeSrc = C_SRC_IMM;
          w_writeImm = w_pcPlus4;
          w_isJalr   = 1'b1;
        end
        default: w_legal = 1'b0;
      endcase
    end
  end

  logic [31:0] w_aluA;
  logic [31:0] w_aluB;
  logic [31:0] w_aluResult;
  assign w_aluA = iwReg1Value;
  assign w_aluB = w_useReg2 ? iwReg2Value : (w_useImmS ? w_immS : w_immI);

  always_comb begin
    case (w_aluOp)
      C_ALU_SUB:  w_aluResult = w_aluA - w_aluB;
      C_ALU_SLL:  w_aluResult = w_aluA << w_aluB[4:0];
      C_ALU_SLT:  w_aluResult = {31'd0, $signed(w_aluA) < $signed(w_aluB)};
      C_ALU_SLTU: w_aluResult = {31'd0, w_aluA < w_aluB};
      C_ALU_XOR:  w_aluResult = w_aluA ^ w_aluB;
      C_ALU_SRL:  w_aluResult = w_aluA >> w_aluB[4:0];
      C_ALU_SRA:  w_aluResult = $unsigned($signed(w_aluA) >>> w_aluB[4:0]);
      C_ALU_OR:   w_aluResult = w_aluA | w_aluB;
      C_ALU_AND:  w_aluResult = w_aluA & w_aluB;
      default:    w_aluResult = w_aluA + w_aluB;
    endcase
  end

  logic w_zero;
  logic w_branchTaken;
  assign w_zero        = (w_aluResult == 32'd0);
  assign w_branchTaken = w_isBranch & (~w_zero ^ w_inverted);

  logic [31:0] w_nextPc;
  always_comb begin
    if (!w_legal)           w_nextPc = iwPc;
    else if (w_isJalr)      w_nextPc = w_aluResult & ~32'd1;
    else if (w_isJal)       w_nextPc = iwPc + w_immJ;
    else if (w_branchTaken) w_nextPc = iwPc + w_immB;
    else                    w_nextPc = w_pcPlus4;
  end

  assign owReadReg1          = w_readReg1;
  assign owReadReg2          = w_readReg2;
  assign owWriteReg          = w_legal ? w_writeReg : 5'd0;
  assign owWriteRegSource    = w_writeSrc;
  assign owWriteRegImmediate = w_writeImm;
  assign owAluResult         = w_aluResult;
  assign owDMemWrite         = w_legal & w_dmemWrite;
  assign owDMemAccess        = w_dmemAccess;
  assign owDMemSignExtend    = w_signExt;
  assign owNextPc            = w_nextPc;
  assign onIllegal           = w_legal;

endmodule

`default_nettype wire

// File: tb/tb_rv32_decode_exec.sv
//------------------------------------------------------------------------------
// Module      : tb_rv32_decode_exec
// Description : Directed self-checking bench for rv32_decode_exec.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rv32_decode_exec;

  logic        clk;
  logic        iwnRst;
  logic [31:0] iwInstruction;
  logic [31:0] iwPc;
  logic [31:0] iwReg1Value;
  logic [31:0] iwReg2Value;
  logic [4:0]  owReadReg1;
  logic [4:0]  owReadReg2;
  logic [4:0]  owWriteReg;
  logic [1:0]  owWriteRegSource;
  logic [31:0] owWriteRegImmediate;
  logic [31:0] owAluResult;
  logic        owDMemWrite;
  logic [1:0]  owDMemAccess;
  logic        owDMemSignExtend;
  logic [31:0] owNextPc;
  logic        onIllegal;

  int nChecks = 0;
  int nPass   = 0;

  rv32_decode_exec dut (
    .iwnRst             (iwnRst),
    .iwInstruction      (iwInstruction),
    .iwPc               (iwPc),
    .iwReg1Value        (iwReg1Value),
    .iwReg2Value        (iwReg2Value),
    .owReadReg1         (owReadReg1),
    .owReadReg2         (owReadReg2),
    .owWriteReg         (owWriteReg),
    .owWriteRegSource   (owWriteRegSource),
    .owWriteRegImmediate(owWriteRegImmediate),
    .owAluResult        (owAluResult),
    .owDMemWrite        (owDMemWrite),
    .owDMemAccess       (owDMemAccess),
    .owDMemSignExtend   (owDMemSignExtend),
    .owNextPc           (owNextPc),
    .onIllegal          (onIllegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Drive on the rising edge, sample half a period later
  task automatic apply(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    @(posedge clk);
    iwInstruction = instr;
    iwPc          = pc;
    iwReg1Value   = r1;
    iwReg2Value   = r2;
    @(negedge clk);
  endtask

  initial begin
    iwnRst        = 1'b0;
    iwInstruction = 32'hFE209F23;
    iwPc          = 32'h0000_0500;
    iwReg1Value   = 32'hDEAD_BEEF;
    iwReg2Value   = 32'h0000_0007;

    // Reset: a store is presented but the block must behave as NOP
    apply(32'hFE209F23, 32'h500, 32'hDEADBEEF, 32'h7);
    check("rst_legal",  {31'd0, onIllegal},   32'd1);
    check("rst_wreg",   {27'd0, owWriteReg},  32'd0);
    check("rst_store",  {31'd0, owDMemWrite}, 32'd0);
    check("rst_alu",    owAluResult,          32'hDEADBEEF);
    check("rst_src",    {30'd0, owWriteRegSource}, 32'd0);
    check("rst_npc",    owNextPc,             32'h504);

    iwnRst = 1'b1;

    // ADDI x1,x0,5
    apply(32'h00500093, 32'h100, 32'h0, 32'h0);
    check("addi_wreg",  {27'd0, owWriteReg},  32'd1);
    check("addi_alu",   owAluResult,          32'd5);
    check("addi_src",   {30'd0, owWriteRegSource}, 32'd0);
    check("addi_npc",   owNextPc,             32'h104);
    check("addi_legal", {31'd0, onIllegal},   32'd1);

    // R-type ALU ops
    apply(32'h4020D1B3, 32'h100, 32'h80000000, 32'd4);
    check("sra",        owAluResult,          32'hF8000000);
    check("sra_rs",     {22'd0, owReadReg1, owReadReg2}, {22'd0, 5'd1, 5'd2});
    apply(32'h0020B1B3, 32'h100, 32'd1, 32'hFFFFFFFF);
    check("sltu",       owAluResult,          32'd1);
    apply(32'h0020A1B3, 32'h100, 32'd1, 32'hFFFFFFFF);
    check("slt",        owAluResult,          32'd0);
    apply(32'h402081B3, 32'h100, 32'd5, 32'd7);
    check("sub",        owAluResult,          32'hFFFFFFFE);
    apply(32'h4040D093, 32'h100, 32'h80000000, 32'd0);
    check("srai",       owAluResult,          32'hF8000000);

    // Branches
    apply(32'h00208863, 32'h200, 32'h1234, 32'h1234);
    check("beq_t_npc",  owNextPc,             32'h210);
    check("beq_wreg",   {27'd0, owWriteReg},  32'd0);
    apply(32'h00208863, 32'h200, 32'h1234, 32'h1235);
    check("beq_nt_npc", owNextPc,             32'h204);
    apply(32'h0020F863, 32'h200, 32'hFFFFFFFF, 32'd1);
    check("bgeu_npc",   owNextPc,             32'h210);

    // Jumps
    apply(32'h002080E7, 32'h40, 32'h1003, 32'h0);
    check("jalr_npc",   owNextPc,             32'h1004);
    check("jalr_link",  owWriteRegImmediate,  32'h44);
    check("jalr_src",   {30'd0, owWriteRegSource}, 32'd2);
    apply(32'h008000EF, 32'h300, 32'h0, 32'h0);
    check("jal_npc",    owNextPc,             32'h308);
    check("jal_link",   owWriteRegImmediate,  32'h304);

    // Upper immediates
    apply(32'h123452B7, 32'h100, 32'h0, 32'h0);
    check("lui_imm",    owWriteRegImmediate,  32'h12345000);
    apply(32'h00001297, 32'h100, 32'h0, 32'h0);
    check("auipc_imm",  owWriteRegImmediate,  32'h00001100);

    // Memory
    apply(32'hFE209F23, 32'h100, 32'h1000, 32'h55);
    check("sh_addr",    owAluResult,          32'hFFE);
    check("sh_we",      {31'd0, owDMemWrite}, 32'd1);
    check("sh_acc",     {30'd0, owDMemAccess}, 32'd1);
    check("sh_wreg",    {27'd0, owWriteReg},  32'd0);
    apply(32'h0000C183, 32'h100, 32'h2000, 32'h0);
    check("lbu_src",    {30'd0, owWriteRegSource}, 32'd1);
    check("lbu_sext",   {31'd0, owDMemSignExtend}, 32'd0);
    check("lbu_wreg",   {27'd0, owWriteReg},  32'd3);
    apply(32'h00008183, 32'h100, 32'h2000, 32'h0);
    check("lb_sext",    {31'd0, owDMemSignExtend}, 32'd1);

    // Illegal encodings
    apply(32'h00000000, 32'h600, 32'h1, 32'h2);
    check("zero_legal", {31'd0, onIllegal},   32'd0);
    check("zero_npc",   owNextPc,             32'h600);
    apply(32'h00000073, 32'h604, 32'h1, 32'h2);
    check("ecall_legal",{31'd0, onIllegal},   32'd0);
    check("ecall_npc",  owNextPc,             32'h604);
    apply(32'h0020A863, 32'h200, 32'h0, 32'h0);
    check("br010_legal",{31'd0, onIllegal},   32'd0);
    apply(32'h40109093, 32'h100, 32'h0, 32'h0);
    check("slli_legal", {31'd0, onIllegal},   32'd0);
    check("slli_wreg",  {27'd0, owWriteReg},  32'd0);
    apply(32'hFE20BF23, 32'h100, 32'h1000, 32'h0);
    check("sd_legal",   {31'd0, onIllegal},   32'd0);
    check("sd_we",      {31'd0, owDMemWrite}, 32'd0);

    // Reset reasserted with an illegal instruction present
    iwnRst = 1'b0;
    apply(32'h00000000, 32'h700, 32'h42, 32'h0);
    check("rst2_legal", {31'd0, onIllegal},   32'd1);
    check("rst2_npc",   owNextPc,             32'h704);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

`default_nettype wire
